mmio_responder: RTL

MMIO_RESPONDER -- requirements
Module: mmio_responder

---
 rtl/mmio_responder_if.sv | 27 ++
 rtl/mmio_responder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mmio_responder_if.sv
// CPU-side MMIO bus: address/data strobes in, load data and decode hit out.
interface mmio_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] rdata;
  logic        hit;

  modport master (
    output addr,
    output wdata,
    output mem_read,
    output mem_write,
    input  rdata,
    input  hit
  );

  modport slave (
    input  addr,
    input  wdata,
    input  mem_read,
    input  mem_write,
    output rdata,
    output hit
  );
endinterface

// File: rtl/mmio_responder.sv
// MMIO peripheral block: reloadable timer with interrupt, LED register,
// four-digit multiplexed hex display and a free-running system tick counter.
module mmio_responder #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic              sysclk,
  input  logic              reset,
  mmio_responder_if.slave   bus,
  output logic              irq,
  output logic [7:0]        leds,
  output logic [7:0]        bcd7,
  output logic [3:0]        an
);

  localparam int unsigned   ScanW   = $clog2(SCAN_DIV);
  localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_DIV - 1);

  // Word addresses (byte address >> 2).
  localparam logic [29:0] AddrTh      = 30'h1000_0000;
  localparam logic [29:0] AddrTl      = 30'h1000_0001;
  localparam logic [29:0] AddrTcon    = 30'h1000_0002;
  localparam logic [29:0] AddrLed     = 30'h1000_0003;
  localparam logic [29:0] AddrDisp    = 30'h1000_0004;
  localparam logic [29:0] AddrSystick = 30'h1000_0005;

  logic [31:0]      th_q, th_d;
  logic [31:0]      tl_q, tl_d;
  logic [2:0]       tcon_q, tcon_d;
  logic [7:0]       led_q, led_d;
  logic [15:0]      disp_q, disp_d;
  logic [31:0]      systick_q, systick_d;
  logic [ScanW-1:0] scan_q, scan_d;
  logic [1:0]       idx_q, idx_d;

  logic sel_th, sel_tl, sel_tcon, sel_led, sel_disp, sel_systick;
  logic wr, timer_run;
  logic [3:0] nibble;
  logic [6:0] seg;

  // Address decode; byte offset bits are ignored.
  always_comb begin
    sel_th      = (bus.addr[31:2] == AddrTh);
    sel_tl      = (bus.addr[31:2] == AddrTl);
    sel_tcon    = (bus.addr[31:2] == AddrTcon);
    sel_led     = (bus.addr[31:2] == AddrLed);
    sel_disp    = (bus.addr[31:2] == AddrDisp);
    sel_systick = (bus.addr[31:2] == AddrSystick);
    bus.hit     = sel_th | sel_tl | sel_tcon | sel_led | sel_disp | sel_systick;
    wr          = bus.mem_write & bus.hit;
    // A CPU store to TL or TCON suppresses the whole timer step that cycle.
    timer_run   = tcon_q[0] & ~(wr & (sel_tl | sel_tcon));
  end

  // Load data mux, zero when not reading a mapped register.
  always_comb begin
    bus.rdata = 32'd0;
    if (bus.mem_read) begin
      if (sel_th)      bus.rdata = th_q;
      if (sel_tl)      bus.rdata = tl_q;
      if (sel_tcon)    bus.rdata = {29'd0, tcon_q};
      if (sel_led)     bus.rdata = {24'd0, led_q};
      if (sel_disp)    bus.rdata = {16'd0, disp_q};
      if (sel_systick) bus.rdata = systick_q;
    end
  end

  // Next-state for registers, timer, tick and scan counters.
  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    led_d     = led_q;
    disp_d    = disp_q;
    systick_d = systick_q + 32'd1;
    scan_d    = scan_q + ScanW'(1);
    idx_d     = idx_q;

    if (timer_run) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        if (tcon_q[1]) tcon_d[2] = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end

    if (wr && sel_th)   th_d   = bus.wdata;
    if (wr && sel_tl)   tl_d   = bus.wdata;
    if (wr && sel_tcon) tcon_d = bus.wdata[2:0];
    if (wr && sel_led)  led_d  = bus.wdata[7:0];
    if (wr && sel_disp) disp_d = bus.wdata[15:0];

    if (scan_q == ScanMax) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      disp_q    <= '0;
      systick_q <= '0;
      scan_q    <= '0;
      idx_q     <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      disp_q    <= disp_d;
      systick_q <= systick_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
    end
  end

  // Segment decode and digit enable both derive from idx_q, so they switch together.
  always_comb begin
    nibble = disp_q[{idx_q, 2'b00} +: 4];
    unique case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
    bcd7 = {1'b0, seg};
    an   = ~(4'b0001 << idx_q);
    leds = led_q;
    irq  = tcon_q[1] & tcon_q[2];
  end

endmodule
